// File: rtl/cpu_bus_arbiter.sv
// Arbitrates the single CPU memory bus between the fetch and memory stages,
// one transaction at a time, with an optional per-transaction watchdog.
module cpu_bus_arbiter #(
    parameter int unsigned DATA_PRIORITY = 1,
    parameter int unsigned TIMEOUT       = 255,
    parameter int unsigned TIMEOUT_WIDTH = 16
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_fetch_request,
    input  logic [31:0] i_fetch_address,
    output logic [31:0] o_fetch_rdata,
    output logic        o_fetch_ready,
    output logic        o_fetch_error,
    input  logic        i_data_request,
    input  logic        i_data_rw,
    input  logic [31:0] i_data_address,
    input  logic [31:0] i_data_wdata,
    output logic [31:0] o_data_rdata,
    output logic        o_data_ready,
    output logic        o_data_error,
    output logic        o_bus_request,
    output logic        o_bus_rw,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ready,
    input  logic [31:0] i_bus_rdata
);

    localparam int unsigned WD_LAST_INT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = TIMEOUT_WIDTH'(WD_LAST_INT);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        GRANT_FETCH = 2'd1,
        GRANT_DATA  = 2'd2
    } state_t;

    state_t                   state, state_next;
    logic                     last_data, last_data_next;
    logic [TIMEOUT_WIDTH-1:0] wd_count, wd_count_next;

    logic        bus_request_next, bus_rw_next;
    logic [31:0] bus_address_next, bus_wdata_next;
    logic [31:0] fetch_rdata_next, data_rdata_next;
    logic        fetch_ready_next, fetch_error_next;
    logic        data_ready_next, data_error_next;

    logic fetch_eligible_c, data_eligible_c, pick_data_c, timeout_hit_c;

    // A requester is still seen requesting during its own ready pulse; mask it out.
    assign fetch_eligible_c = i_fetch_request & ~o_fetch_ready;
    assign data_eligible_c  = i_data_request & ~o_data_ready;
    assign pick_data_c      = data_eligible_c &
                              (~fetch_eligible_c | (DATA_PRIORITY != 0) | ~last_data);
    assign timeout_hit_c    = (TIMEOUT != 0) && (wd_count == WD_LAST);

    // State and registered outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state         <= IDLE;
            last_data     <= 1'b0;
            wd_count      <= '0;
            o_bus_request <= 1'b0;
            o_bus_rw      <= 1'b0;
            o_bus_address <= '0;
            o_bus_wdata   <= '0;
            o_fetch_rdata <= '0;
            o_fetch_ready <= 1'b0;
            o_fetch_error <= 1'b0;
            o_data_rdata  <= '0;
            o_data_ready  <= 1'b0;
            o_data_error  <= 1'b0;
        end else begin
            state         <= state_next;
            last_data     <= last_data_next;
            wd_count      <= wd_count_next;
            o_bus_request <= bus_request_next;
            o_bus_rw      <= bus_rw_next;
            o_bus_address <= bus_address_next;
            o_bus_wdata   <= bus_wdata_next;
            o_fetch_rdata <= fetch_rdata_next;
            o_fetch_ready <= fetch_ready_next;
            o_fetch_error <= fetch_error_next;
            o_data_rdata  <= data_rdata_next;
            o_data_ready  <= data_ready_next;
            o_data_error  <= data_error_next;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next       = state;
        last_data_next   = last_data;
        wd_count_next    = wd_count;
        bus_request_next = o_bus_request;
        bus_rw_next      = o_bus_rw;
        bus_address_next = o_bus_address;
        bus_wdata_next   = o_bus_wdata;
        fetch_rdata_next = o_fetch_rdata;
        fetch_ready_next = 1'b0;
        fetch_error_next = 1'b0;
        data_rdata_next  = o_data_rdata;
        data_ready_next  = 1'b0;
        data_error_next  = 1'b0;

        case (state)
            IDLE: begin
                bus_request_next = 1'b0;
                if (pick_data_c) begin
                    state_next       = GRANT_DATA;
                    last_data_next   = 1'b1;
                    wd_count_next    = '0;
                    bus_request_next = 1'b1;
                    bus_rw_next      = i_data_rw;
                    bus_address_next = i_data_address;
                    bus_wdata_next   = i_data_wdata;
                end else if (fetch_eligible_c) begin
                    state_next       = GRANT_FETCH;
                    last_data_next   = 1'b0;
                    wd_count_next    = '0;
                    bus_request_next = 1'b1;
                    bus_rw_next      = 1'b0;
                    bus_address_next = i_fetch_address;
                    bus_wdata_next   = '0;
                end
            end
            GRANT_FETCH, GRANT_DATA: begin
                // Bus ready beats the watchdog when both land in the same cycle.
                if (i_bus_ready || timeout_hit_c) begin
                    state_next       = IDLE;
                    bus_request_next = 1'b0;
                    if (state == GRANT_DATA) begin
                        data_ready_next = 1'b1;
                        data_error_next = ~i_bus_ready;
                        data_rdata_next = (i_bus_ready && !o_bus_rw) ? i_bus_rdata : '0;
                    end else begin
                        fetch_ready_next = 1'b1;
                        fetch_error_next = ~i_bus_ready;
                        fetch_rdata_next = i_bus_ready ? i_bus_rdata : '0;
                    end
                end else begin
                    wd_count_next = wd_count + TIMEOUT_WIDTH'(1);
                end
            end
            default: begin
                state_next       = IDLE;
                bus_request_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: a fixed-priority and a round-robin instance share
// stimulus; a bus responder model and completion scoreboard check the selected one.
module tb_cpu_bus_arbiter;

    localparam int unsigned TO = 8;

    typedef struct {
        logic        is_data;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bus_rdata;
        int          waits;
        logic [31:0] exp_rdata;
        logic        exp_error;
        int          exp_cycles;
    } vec_t;

    typedef struct {
        logic        is_data;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        error;
        int          cycles;
    } exp_t;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_fetch_request;
    logic [31:0] i_fetch_address;
    logic        i_data_request;
    logic        i_data_rw;
    logic [31:0] i_data_address;
    logic [31:0] i_data_wdata;
    logic        i_bus_ready;
    logic [31:0] i_bus_rdata;

    logic [31:0] a_fetch_rdata, b_fetch_rdata, a_data_rdata, b_data_rdata;
    logic        a_fetch_ready, b_fetch_ready, a_fetch_error, b_fetch_error;
    logic        a_data_ready, b_data_ready, a_data_error, b_data_error;
    logic        a_bus_request, b_bus_request, a_bus_rw, b_bus_rw;
    logic [31:0] a_bus_address, b_bus_address, a_bus_wdata, b_bus_wdata;

    logic        sel;
    logic [31:0] m_fetch_rdata, m_data_rdata, m_bus_address, m_bus_wdata;
    logic        m_fetch_ready, m_fetch_error, m_data_ready, m_data_error;
    logic        m_bus_request, m_bus_rw;

    always #5 i_clock = ~i_clock;

    cpu_bus_arbiter #(.DATA_PRIORITY(1), .TIMEOUT(TO), .TIMEOUT_WIDTH(16)) dut_dp (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_fetch_request(i_fetch_request), .i_fetch_address(i_fetch_address),
        .o_fetch_rdata(a_fetch_rdata), .o_fetch_ready(a_fetch_ready), .o_fetch_error(a_fetch_error),
        .i_data_request(i_data_request), .i_data_rw(i_data_rw),
        .i_data_address(i_data_address), .i_data_wdata(i_data_wdata),
        .o_data_rdata(a_data_rdata), .o_data_ready(a_data_ready), .o_data_error(a_data_error),
        .o_bus_request(a_bus_request), .o_bus_rw(a_bus_rw),
        .o_bus_address(a_bus_address), .o_bus_wdata(a_bus_wdata),
        .i_bus_ready(i_bus_ready), .i_bus_rdata(i_bus_rdata)
    );

    cpu_bus_arbiter #(.DATA_PRIORITY(0), .TIMEOUT(TO), .TIMEOUT_WIDTH(16)) dut_rr (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_fetch_request(i_fetch_request), .i_fetch_address(i_fetch_address),
        .o_fetch_rdata(b_fetch_rdata), .o_fetch_ready(b_fetch_ready), .o_fetch_error(b_fetch_error),
        .i_data_request(i_data_request), .i_data_rw(i_data_rw),
        .i_data_address(i_data_address), .i_data_wdata(i_data_wdata),
        .o_data_rdata(b_data_rdata), .o_data_ready(b_data_ready), .o_data_error(b_data_error),
        .o_bus_request(b_bus_request), .o_bus_rw(b_bus_rw),
        .o_bus_address(b_bus_address), .o_bus_wdata(b_bus_wdata),
        .i_bus_ready(i_bus_ready), .i_bus_rdata(i_bus_rdata)
    );

    assign m_fetch_rdata = sel ? b_fetch_rdata : a_fetch_rdata;
    assign m_fetch_ready = sel ? b_fetch_ready : a_fetch_ready;
    assign m_fetch_error = sel ? b_fetch_error : a_fetch_error;
    assign m_data_rdata  = sel ? b_data_rdata  : a_data_rdata;
    assign m_data_ready  = sel ? b_data_ready  : a_data_ready;
    assign m_data_error  = sel ? b_data_error  : a_data_error;
    assign m_bus_request = sel ? b_bus_request : a_bus_request;
    assign m_bus_rw      = sel ? b_bus_rw      : a_bus_rw;
    assign m_bus_address = sel ? b_bus_address : a_bus_address;
    assign m_bus_wdata   = sel ? b_bus_wdata   : a_bus_wdata;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t e;
    int   run = 0;
    int   last_run = 0;
    int   bus_cnt = 0;
    int   wait_cfg = 0;
    logic [31:0] rdata_cfg = '0;
    int   f_left = 0, d_left = 0;
    bit   f_drop = 0, d_drop = 0;
    vec_t vecs [8];
    vec_t vd, vf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: bus fields against the head entry, completions popped in order.
    always @(negedge i_clock) begin
        if (m_bus_request === 1'b1) run++;
        else if (run != 0) begin
            last_run = run;
            run = 0;
        end
        if (m_bus_request === 1'b1) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL spurious_grant: bus_request=1 with no transaction expected");
            end else begin
                chk("bus_rw", 32'(m_bus_rw), 32'(sb[0].rw));
                chk("bus_address", m_bus_address, sb[0].addr);
                chk("bus_wdata", m_bus_wdata, sb[0].wdata);
            end
        end
        if (m_fetch_ready === 1'b1 || m_data_ready === 1'b1) begin
            chk("ready_bus_idle", 32'(m_bus_request), 32'd0);
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL spurious_ready: fetch_ready=%b data_ready=%b", m_fetch_ready, m_data_ready);
            end else begin
                e = sb.pop_front();
                chk("ready_port", 32'({m_data_ready, m_fetch_ready}), e.is_data ? 32'd2 : 32'd1);
                chk("rdata", e.is_data ? m_data_rdata : m_fetch_rdata, e.rdata);
                chk("error", 32'(e.is_data ? m_data_error : m_fetch_error), 32'(e.error));
                chk("bus_cycles", 32'(last_run), 32'(e.cycles));
            end
        end else if (m_fetch_error === 1'b1 || m_data_error === 1'b1) begin
            checks++; failures++;
            $display("FAIL error_without_ready: fetch_error=%b data_error=%b", m_fetch_error, m_data_error);
        end
    end

    // One clock step: requester hold/drop behaviour plus the bus responder.
    task automatic cycle();
        @(posedge i_clock);
        #1;
        if (f_drop) begin i_fetch_request = 1'b0; f_drop = 0; end
        if (d_drop) begin i_data_request = 1'b0; d_drop = 0; end
        if (m_fetch_ready === 1'b1 && f_left > 0) begin f_left--; if (f_left == 0) f_drop = 1; end
        if (m_data_ready === 1'b1 && d_left > 0) begin d_left--; if (d_left == 0) d_drop = 1; end
        if (m_bus_request === 1'b1) begin
            bus_cnt++;
            i_bus_ready = (bus_cnt == wait_cfg + 1);
            i_bus_rdata = rdata_cfg;
        end else begin
            bus_cnt = 0;
            i_bus_ready = 1'b0;
            i_bus_rdata = $urandom;
        end
    endtask

    task automatic drive(input vec_t v, input int n);
        wait_cfg  = v.waits;
        rdata_cfg = v.bus_rdata;
        if (v.is_data) begin
            i_data_request = 1'b1; i_data_rw = v.rw;
            i_data_address = v.addr; i_data_wdata = v.wdata; d_left = n;
        end else begin
            i_fetch_request = 1'b1; i_fetch_address = v.addr; f_left = n;
        end
    endtask

    task automatic expect_txn(input vec_t v);
        exp_t x;
        x.is_data = v.is_data;
        x.rw      = v.is_data ? v.rw : 1'b0;
        x.addr    = v.addr;
        x.wdata   = v.is_data ? v.wdata : 32'd0;
        x.rdata   = v.exp_rdata;
        x.error   = v.exp_error;
        x.cycles  = v.exp_cycles;
        sb.push_back(x);
    endtask

    task automatic wait_done(input int max);
        for (int i = 0; i < max; i++) begin
            if (sb.size() == 0) break;
            cycle();
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL wait_done: %0d transactions still outstanding", sb.size());
            sb.delete();
            i_fetch_request = 1'b0; i_data_request = 1'b0; f_left = 0; d_left = 0;
        end
        repeat (2) cycle();
    endtask

    task automatic do_reset();
        i_fetch_request = 1'b0; i_data_request = 1'b0; f_left = 0; d_left = 0;
        i_reset = 1'b1;
        repeat (2) cycle();
        chk("rst_bus_request", 32'(m_bus_request), 32'd0);
        chk("rst_bus_address", m_bus_address, 32'd0);
        chk("rst_fetch_ready", 32'({m_fetch_ready, m_fetch_error}), 32'd0);
        chk("rst_data_ready", 32'({m_data_ready, m_data_error}), 32'd0);
        chk("rst_fetch_rdata", m_fetch_rdata, 32'd0);
        chk("rst_data_rdata", m_data_rdata, 32'd0);
        i_reset = 1'b0;
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        sel = 1'b0;
        i_reset = 1'b1; i_fetch_request = 1'b0; i_fetch_address = 32'h0;
        i_data_request = 1'b0; i_data_rw = 1'b1; i_data_address = 32'hFFFF_FFFF;
        i_data_wdata = 32'hFFFF_FFFF; i_bus_ready = 1'b0; i_bus_rdata = '0;

        //          data rw   addr           wdata          bus_rdata      waits exp_rdata      err cyc
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 3,    32'hDEAD_BEEF, 1'b0, 4};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678, 32'hFFFF_0000, 0,    32'h0,         1'b0, 1};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0,        32'hCAFE_F00D, 1,    32'hCAFE_F00D, 1'b0, 2};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,        32'h1111_1111, 1000, 32'h0,         1'b1, 8};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0108, 32'h0,        32'h0BAD_F00D, 7,    32'h0BAD_F00D, 1'b0, 8};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_3004, 32'h0,        32'h2222_2222, 1000, 32'h0,         1'b1, 8};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_3008, 32'h0,        32'h55AA_55AA, 6,    32'h55AA_55AA, 1'b0, 7};
        vecs[7] = '{1'b0, 1'b0, 32'h0000_010C, 32'h0,        32'hA5A5_A5A5, 0,    32'hA5A5_A5A5, 1'b0, 1};

        do_reset();
        for (int i = 0; i < 8; i++) begin
            expect_txn(vecs[i]);
            drive(vecs[i], 1);
            wait_done(40);
        end
        chk("fetch_rdata_hold", m_fetch_rdata, 32'hA5A5_A5A5);
        chk("data_rdata_hold", m_data_rdata, 32'h55AA_55AA);

        // Simultaneous requests, fixed priority: data then fetch.
        vd = '{1'b1, 1'b0, 32'h0000_4000, 32'h0, 32'h1111_2222, 1, 32'h1111_2222, 1'b0, 2};
        vf = '{1'b0, 1'b0, 32'h0000_0500, 32'h0, 32'h1111_2222, 1, 32'h1111_2222, 1'b0, 2};
        expect_txn(vd); expect_txn(vf);
        drive(vd, 1); drive(vf, 1);
        wait_done(40);

        // Reset on the second wait cycle of a data read; held request restarts it.
        begin
            vec_t vr;
            vr = '{1'b1, 1'b0, 32'h0000_6000, 32'h0, 32'h7777_8888, 2, 32'h7777_8888, 1'b0, 3};
            expect_txn(vr);
            drive(vr, 1);
            for (int i = 0; i < 20; i++) begin
                cycle();
                if (m_bus_request === 1'b1 && bus_cnt == 2) break;
            end
            chk("pre_reset_bus_cycle", 32'(bus_cnt), 32'd2);
            i_reset = 1'b1;
            cycle();
            chk("mid_reset_bus_request", 32'(m_bus_request), 32'd0);
            chk("mid_reset_data_ready", 32'(m_data_ready), 32'd0);
            i_reset = 1'b0;
            wait_done(40);
        end

        // Round-robin instance: held requests alternate data, fetch, data, fetch.
        sel = 1'b1;
        do_reset();
        expect_txn(vd); expect_txn(vf); expect_txn(vd); expect_txn(vf);
        drive(vd, 2); drive(vf, 2);
        wait_done(80);

        // After a data grant, a simultaneous pair goes to fetch first.
        expect_txn(vd);
        drive(vd, 1);
        wait_done(40);
        expect_txn(vf); expect_txn(vd);
        drive(vd, 1); drive(vf, 1);
        wait_done(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
